// File: rtl/dc_bus_pkg.sv
// Shared definitions for the SH4-side data bus: region codes, address windows
// and the responder FSM state encoding.
package dc_bus_pkg;

  typedef enum logic [1:0] {
    REG_PVR      = 2'd0,
    REG_VRAM     = 2'd1,
    REG_SDRAM    = 2'd2,
    REG_UNMAPPED = 2'd3
  } dm_region_e;

  // Windows are inclusive and apply to addr[28:0] (upper bits are mirrors).
  localparam logic [28:0] PVR_BASE          = 29'h005F_7C00;
  localparam logic [28:0] PVR_LIMIT         = 29'h005F_9FFF;
  localparam logic [28:0] VRAM_BASE         = 29'h0400_0000;
  localparam logic [28:0] VRAM_LIMIT        = 29'h047F_FFFF;
  localparam logic [28:0] VRAM_MIRROR_BASE  = 29'h0600_0000;
  localparam logic [28:0] VRAM_MIRROR_LIMIT = 29'h067F_FFFF;
  localparam logic [28:0] SDRAM_BASE        = 29'h0C00_0000;
  localparam logic [28:0] SDRAM_LIMIT       = 29'h0CFF_FFFF;

  typedef logic [2:0] dm_state_t;
  localparam dm_state_t ST_IDLE     = 3'd0;
  localparam dm_state_t ST_PVR_ACC  = 3'd1;
  localparam dm_state_t ST_PVR_CAP  = 3'd2;
  localparam dm_state_t ST_EXT_WAIT = 3'd3;
  localparam dm_state_t ST_RESP     = 3'd4;

  function automatic logic in_window(input logic [28:0] a,
                                     input logic [28:0] base,
                                     input logic [28:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/dm_addr_decode.sv
// Combinational map from a 29-bit physical address to a bus region and the
// 24-bit offset presented to the selected target.
module dm_addr_decode
  import dc_bus_pkg::*;
(
  input  logic [28:0] addr_i,
  output dm_region_e  region_o,
  output logic [23:0] offset_o
);

  always_comb begin
    region_o = REG_UNMAPPED;
    if (in_window(addr_i, PVR_BASE, PVR_LIMIT)) begin
      region_o = REG_PVR;
    end else if (in_window(addr_i, VRAM_BASE, VRAM_LIMIT) ||
                 in_window(addr_i, VRAM_MIRROR_BASE, VRAM_MIRROR_LIMIT)) begin
      region_o = REG_VRAM;
    end else if (in_window(addr_i, SDRAM_BASE, SDRAM_LIMIT)) begin
      region_o = REG_SDRAM;
    end
  end

  assign offset_o = addr_i[23:0];

endmodule

// File: rtl/sh4_dm_responder.sv
// Responder for the SH4 data-memory port: decodes each request to PVR, VRAM or
// SDRAM, runs that target's handshake and returns a single-cycle response.
module sh4_dm_responder
  import dc_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [63:0] UNMAPPED_RDATA = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic [15:0] pvr_reg_addr,
  output logic [31:0] pvr_reg_wdata,
  output logic        pvr_reg_rd,
  output logic        pvr_reg_wr,
  input  logic [31:0] pvr_reg_rdata,
  output logic [23:0] vram_addr,
  output logic [63:0] vram_wdata,
  output logic [7:0]  vram_wmask,
  output logic        vram_wen,
  output logic        vram_req,
  input  logic [63:0] vram_rdata,
  input  logic        vram_ack,
  output logic [23:0] sdram_addr,
  output logic [63:0] sdram_wdata,
  output logic [7:0]  sdram_wmask,
  output logic        sdram_wen,
  output logic        sdram_req,
  input  logic [63:0] sdram_rdata,
  input  logic        sdram_ack,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [31:0] err_addr,
  output dm_state_t   dbg_state
);

  // Handshake: the core holds dm_req_valid and its fields stable until it sees
  // the one-cycle dm_resp_valid; valid seen in IDLE is always a new request.
  // Targets hold *_req until they return a one-cycle *_ack with read data.

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  dm_state_t   state_q, state_d;
  dm_region_e  region_q, dec_region;
  logic [23:0] offset_q, dec_offset;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        wen_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        bus_err_q;
  logic [31:0] err_addr_q;
  logic        err_set;
  logic [31:0] err_set_addr;
  logic        accept;
  logic        tgt_ack;
  logic [63:0] tgt_rdata;

  dm_addr_decode u_decode (
    .addr_i   (dm_req_addr[28:0]),
    .region_o (dec_region),
    .offset_o (dec_offset)
  );

  assign accept    = (state_q == ST_IDLE) && dm_req_valid;
  assign tgt_ack   = (region_q == REG_VRAM) ? vram_ack : sdram_ack;
  assign tgt_rdata = (region_q == REG_VRAM) ? vram_rdata : sdram_rdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_set      = 1'b0;
    err_set_addr = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_req_valid) begin
          cnt_d   = '0;
          rdata_d = '0;
          case (dec_region)
            REG_PVR:   state_d = ST_PVR_ACC;
            REG_VRAM,
            REG_SDRAM: state_d = ST_EXT_WAIT;
            default: begin
              state_d      = ST_RESP;
              err_set      = 1'b1;
              err_set_addr = dm_req_addr;
              rdata_d      = dm_req_wen ? 64'h0 : UNMAPPED_RDATA;
            end
          endcase
        end
      end
      ST_PVR_ACC: state_d = ST_PVR_CAP;
      ST_PVR_CAP: begin
        rdata_d = wen_q ? 64'h0 : {pvr_reg_rdata, pvr_reg_rdata};
        state_d = ST_RESP;
      end
      ST_EXT_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (tgt_ack) begin
          rdata_d = wen_q ? 64'h0 : tgt_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // Request has been held for TIMEOUT_CYCLES cycles: give up on it.
          rdata_d = wen_q ? 64'h0 : UNMAPPED_RDATA;
          err_set = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      region_q <= REG_UNMAPPED;
      offset_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wen_q    <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        region_q <= dec_region;
        offset_q <= dec_offset;
        addr_q   <= dm_req_addr;
        wdata_q  <= dm_req_wdata;
        wmask_q  <= dm_req_wmask;
        wen_q    <= dm_req_wen;
      end
    end
  end

  // A new error overrides a simultaneous clear; otherwise the first error sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else if (err_set && (!bus_err_q || err_clr)) begin
      bus_err_q  <= 1'b1;
      err_addr_q <= err_set_addr;
    end else if (err_clr) begin
      bus_err_q <= 1'b0;
    end
  end

  assign pvr_reg_addr  = addr_q[15:0];
  assign pvr_reg_wdata = addr_q[2] ? wdata_q[63:32] : wdata_q[31:0];
  assign pvr_reg_rd    = (state_q == ST_PVR_ACC) && !wen_q;
  assign pvr_reg_wr    = (state_q == ST_PVR_ACC) && wen_q && (|wmask_q);

  assign vram_addr   = offset_q;
  assign vram_wdata  = wdata_q;
  assign vram_wmask  = wmask_q;
  assign vram_wen    = wen_q && (region_q == REG_VRAM);
  assign vram_req    = (state_q == ST_EXT_WAIT) && (region_q == REG_VRAM);

  assign sdram_addr  = offset_q;
  assign sdram_wdata = wdata_q;
  assign sdram_wmask = wmask_q;
  assign sdram_wen   = wen_q && (region_q == REG_SDRAM);
  assign sdram_req   = (state_q == ST_EXT_WAIT) && (region_q == REG_SDRAM);

  assign dm_resp_valid = (state_q == ST_RESP);
  assign dm_resp_rdata = rdata_q;
  assign bus_err       = bus_err_q;
  assign err_addr      = err_addr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sh4_dm_responder.sv
// Directed bench for sh4_dm_responder: scoreboard of expected responses plus
// cycle-exact checks of target strobes, errors and reset behaviour.
module tb_sh4_dm_responder;
  import dc_bus_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] dm_req_addr;
  logic [63:0] dm_req_wdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_req_wen;
  logic        dm_req_valid;
  logic [63:0] dm_resp_rdata;
  logic        dm_resp_valid;
  logic [15:0] pvr_reg_addr;
  logic [31:0] pvr_reg_wdata;
  logic        pvr_reg_rd;
  logic        pvr_reg_wr;
  logic [31:0] pvr_reg_rdata;
  logic [23:0] vram_addr;
  logic [63:0] vram_wdata;
  logic [7:0]  vram_wmask;
  logic        vram_wen;
  logic        vram_req;
  logic [63:0] vram_rdata;
  logic        vram_ack;
  logic [23:0] sdram_addr;
  logic [63:0] sdram_wdata;
  logic [7:0]  sdram_wmask;
  logic        sdram_wen;
  logic        sdram_req;
  logic [63:0] sdram_rdata;
  logic        sdram_ack;
  logic        err_clr;
  logic        bus_err;
  logic [31:0] err_addr;
  dm_state_t   dbg_state;

  logic [63:0] exp_q[$];
  int checks;
  int failures;

  sh4_dm_responder #(.TIMEOUT_CYCLES(8), .UNMAPPED_RDATA(64'h0)) dut (
    .clk(clk), .rst(rst),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_req_wmask(dm_req_wmask), .dm_req_wen(dm_req_wen),
    .dm_req_valid(dm_req_valid),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .pvr_reg_addr(pvr_reg_addr), .pvr_reg_wdata(pvr_reg_wdata),
    .pvr_reg_rd(pvr_reg_rd), .pvr_reg_wr(pvr_reg_wr),
    .pvr_reg_rdata(pvr_reg_rdata),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_wmask(vram_wmask),
    .vram_wen(vram_wen), .vram_req(vram_req), .vram_rdata(vram_rdata),
    .vram_ack(vram_ack),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata),
    .sdram_wmask(sdram_wmask), .sdram_wen(sdram_wen), .sdram_req(sdram_req),
    .sdram_rdata(sdram_rdata), .sdram_ack(sdram_ack),
    .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (dm_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected act=%h req=none", dm_resp_rdata);
      end else begin
        chk("resp_rdata", dm_resp_rdata, exp_q.pop_front());
      end
    end
  end

  // Driver tasks: issue returns at the negedge of the accept cycle N.
  task automatic issue(input logic [31:0] a, input logic [63:0] wd,
                       input logic [7:0] wm, input logic we,
                       input logic exp_resp, input logic [63:0] exp_rd);
    @(posedge clk);
    #1;
    dm_req_addr  = a;
    dm_req_wdata = wd;
    dm_req_wmask = wm;
    dm_req_wen   = we;
    dm_req_valid = 1'b1;
    if (exp_resp) exp_q.push_back(exp_rd);
    @(negedge clk);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    dm_req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0;
    dm_req_wen = 1'b0; dm_req_valid = 1'b0;
    pvr_reg_rdata = 32'hDEAD_DEAD;
    vram_rdata = 64'hBAD0_BAD0_BAD0_BAD0; vram_ack = 1'b0;
    sdram_rdata = 64'hBAD1_BAD1_BAD1_BAD1; sdram_ack = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    chk("rst_resp_valid", 64'(dm_resp_valid), 64'h0);
    chk("rst_resp_rdata", dm_resp_rdata, 64'h0);
    chk("rst_strobes", 64'({pvr_reg_rd, pvr_reg_wr, vram_req, sdram_req}), 64'h0);
    chk("rst_bus_err", 64'(bus_err), 64'h0);
    chk("rst_err_addr", 64'(err_addr), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // PVR read: strobe in N+1, rdata present only in N+2, response in N+3.
    issue(32'h005F_8000, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h1234_5678_1234_5678);
    step();
    chk("pvr_rd_pulse", 64'({pvr_reg_rd, pvr_reg_wr}), 64'h2);
    chk("pvr_rd_addr", 64'(pvr_reg_addr), 64'h8000);
    step();
    chk("pvr_rd_drop", 64'({pvr_reg_rd, dm_resp_valid}), 64'h0);
    pvr_reg_rdata = 32'h1234_5678;
    step();
    pvr_reg_rdata = 32'hDEAD_DEAD;
    chk("pvr_rd_resp_n3", 64'(dm_resp_valid), 64'h1);
    release_req();
    chk("pvr_rd_resp_pulse", 64'(dm_resp_valid), 64'h0);

    // SDRAM write with ack in the fifth req cycle.
    issue(32'h0C00_0010, 64'h1111_2222_3333_4444, 8'h0F, 1'b1, 1'b1, 64'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("sdram_wr_req", 64'(sdram_req), 64'h1);
      chk("sdram_wr_no_resp", 64'(dm_resp_valid), 64'h0);
      if (k == 1) begin
        chk("sdram_wr_addr", 64'(sdram_addr), 64'h10);
        chk("sdram_wr_wen_mask", 64'({sdram_wen, sdram_wmask}), 64'h10F);
        chk("sdram_wr_wdata", sdram_wdata, 64'h1111_2222_3333_4444);
        chk("sdram_wr_vram_idle", 64'(vram_req), 64'h0);
      end
      if (k == 5) sdram_ack = 1'b1;
    end
    step();
    sdram_ack = 1'b0;
    chk("sdram_wr_req_drop", 64'(sdram_req), 64'h0);
    chk("sdram_wr_resp", 64'(dm_resp_valid), 64'h1);
    release_req();
    chk("sdram_wr_resp_pulse", 64'(dm_resp_valid), 64'h0);

    // Unmapped reads: first error sticks, clear drops the flag.
    issue(32'h0800_0000, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h0);
    step();
    chk("unm_resp_n1", 64'(dm_resp_valid), 64'h1);
    chk("unm_bus_err", 64'(bus_err), 64'h1);
    chk("unm_err_addr", 64'(err_addr), 64'h0800_0000);
    release_req();
    issue(32'h1000_0000, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h0);
    step();
    chk("unm2_resp_n1", 64'(dm_resp_valid), 64'h1);
    chk("unm2_err_addr_kept", 64'(err_addr), 64'h0800_0000);
    release_req();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", 64'(bus_err), 64'h0);

    // VRAM mirror read with no ack: times out after 8 req cycles.
    issue(32'h0600_0020, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("to_vram_req", 64'(vram_req), 64'h1);
      if (k == 1) chk("to_vram_addr", 64'(vram_addr), 64'h20);
      sdram_ack = (k == 3);
    end
    step();
    sdram_ack = 1'b0;
    chk("to_req_drop", 64'(vram_req), 64'h0);
    chk("to_resp", 64'(dm_resp_valid), 64'h1);
    chk("to_bus_err", 64'(bus_err), 64'h1);
    chk("to_err_addr", 64'(err_addr), 64'h0600_0020);
    vram_ack = 1'b1;
    release_req();
    chk("late_ack_ignored", 64'({dm_resp_valid, vram_req}), 64'h0);
    vram_ack = 1'b0;
    step();
    chk("late_ack_idle", 64'(dbg_state), 64'(ST_IDLE));

    // SDRAM read then PVR write accepted in the cycle after the response.
    issue(32'h0C00_0100, 64'h0, 8'hFF, 1'b0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
    step();
    chk("b2b_sdram_req", 64'(sdram_req), 64'h1);
    step();
    sdram_ack = 1'b1;
    sdram_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
    step();
    sdram_ack = 1'b0;
    sdram_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
    chk("b2b_sdram_resp", 64'(dm_resp_valid), 64'h1);
    issue(32'h005F_8004, 64'hCAFE_BABE_1122_3344, 8'hF0, 1'b1, 1'b1, 64'h0);
    chk("b2b_accept_idle", 64'(dbg_state), 64'(ST_IDLE));
    step();
    chk("b2b_pvr_wr", 64'({pvr_reg_rd, pvr_reg_wr}), 64'h1);
    chk("b2b_pvr_hi_lane", 64'(pvr_reg_wdata), 64'hCAFE_BABE);
    chk("b2b_pvr_addr", 64'(pvr_reg_addr), 64'h8004);
    step();
    step();
    chk("b2b_pvr_resp", 64'(dm_resp_valid), 64'h1);
    release_req();

    // PVR write, low lane, empty mask: no strobe but still responds.
    issue(32'h005F_8008, 64'hCAFE_BABE_1122_3344, 8'h00, 1'b1, 1'b1, 64'h0);
    step();
    chk("pvr_nomask_no_wr", 64'({pvr_reg_rd, pvr_reg_wr}), 64'h0);
    chk("pvr_lo_lane", 64'(pvr_reg_wdata), 64'h1122_3344);
    step();
    step();
    chk("pvr_nomask_resp", 64'(dm_resp_valid), 64'h1);
    release_req();

    // Reset in EXT_WAIT: strobes drop next cycle, no response follows.
    issue(32'h0C00_0200, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0);
    step();
    chk("rst_mid_req", 64'(sdram_req), 64'h1);
    step();
    rst = 1'b1;
    dm_req_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_mid_strobes", 64'({pvr_reg_rd, pvr_reg_wr, vram_req, sdram_req}), 64'h0);
    chk("rst_mid_no_resp", 64'(dm_resp_valid), 64'h0);
    chk("rst_mid_bus_err", 64'(bus_err), 64'h0);
    repeat (4) step();
    chk("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
